life_engine: RTL
================

Name: life_engine

Overview:
- Holds the 16x16 Game of Life board and advances it one generation per `step` pulse.
- `step` is driven by the counter_1s tick.
- Cursor edits arrive from the debounced-button/position stage as (cur_x, cur_y) plus a toggle pulse.
- Sits between the cursor/speed control stage (upstream) and the board display stage (downstream), which reads rows through rd_row/rd_data.

Parameters:
- GRID_N, 16, board side in cells. Fixed power of two ≤16. Coordinate width CW = $clog2(GRID_N).
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- step  in  1  single-cycle request to compute one generation
- toggle  in  1  single-cycle request to invert cell (cur_x, cur_y)
- clear  in  1  single-cycle request to kill all cells
- cur_x  in  CW  cursor column; cell bit index within a row
- cur_y  in  CW  cursor row index
- rd_row  in  CW  display read row address
- rd_data  out  GRID_N  combinational contents of row rd_row; bit x = cell (x, rd_row)
- busy  out  1  generation in progress
- done  out  1  one-cycle pulse when a generation completes
- stable  out  1  last completed generation changed no cell
- gen_count  out  GEN_W  completed generations, wraps

Behaviour:
- Reset (async, rst_n=0):
  - board all 0; gen_count=0; busy=0; done=0; stable=0.
  - FSM to IDLE; pending toggle and pending step cleared.
- FSM states: IDLE, COMPUTE. Row index r counts 0..GRID_N-1.
- IDLE, step sampled at edge E:
  - busy=1 from E.
  - Row r's new value is written at edge E+1+r.
  - At edge E+GRID_N: busy=0, done=1 for one cycle, gen_count+=1, stable updated; FSM returns to IDLE.
  - Total latency: GRID_N+1 cycles from step to done.
- Row computation, in place, one row per cycle:
  - Neighbours of row r use old row r-1 (held in register prev_old), old row r (still in the board), and old row r+1.
  - After writing row r, its old value moves into prev_old.
  - Old row 0 is kept in row0_old for use by the last row.
- Next-state rule, per cell with live-neighbour count n (0..8, 4-bit sum): alive' = (n==3) | (alive & n==2).
- stable = 1 iff every written row equalled its old value during that generation.
- gen_count: GEN_W-bit; 2^GEN_W-1 wraps to 0 with no flag.
- Priority in IDLE: clear > toggle > step.
  - clear: board zeroed next edge; gen_count and stable untouched.
  - toggle and step in the same cycle: toggle applied at that edge; step held pending and starts COMPUTE on the following cycle.
  - clear and toggle together: toggle discarded.
- Events during COMPUTE:
  - step: ignored (dropped).
  - toggle: latched one-deep with the cur_x/cur_y captured at that cycle; applied in the cycle done is high. A second toggle while one is pending overwrites the first.
  - clear: aborts immediately; board zeroed, FSM to IDLE, busy=0, no done, gen_count unchanged, pending toggle discarded.
- rd_data is valid only while busy=0; during COMPUTE it shows a mix of old and new rows.
- Reset asserted mid-COMPUTE: all state to reset values immediately.

Optional Feature:
- Macro LIFE_WRAP_EN.
- Defined: toroidal board; row -1 is row GRID_N-1, column -1 is column GRID_N-1, and symmetrically at the far edges.
- Undefined: every cell outside the board counts as dead; row0_old is not needed and is removed.

Test Plan:
- Reset, then toggle (7,6),(7,7),(7,8) → rows 6,7,8 = 0x0080. Step → done exactly 17 cycles after step; row7=0x01C0, rows 6 and 8 = 0; gen_count=1; stable=0.
- Toggle (0,0),(1,0),(0,1),(1,1), step → rows 0,1 = 0x0003 unchanged; stable=1; gen_count=1.
- Row 0 = 0x0007, step:
  - with LIFE_WRAP_EN: rows 15,0,1 = 0x0002.
  - without LIFE_WRAP_EN: rows 0,1 = 0x0002, row15 = 0.
- Step, then toggle (5,5) at cycle 3 of COMPUTE, plus a second step at cycle 4 → (5,5) inverted in the done cycle; only one generation counted (gen_count +1).
- Blinker loaded, step, clear at cycle 8 of COMPUTE → busy=0 next cycle, all rows 0, done never pulses, gen_count unchanged. Then drop rst_n mid-COMPUTE → gen_count=0, busy=0 asynchronously.
- Force gen_count to 0xFFFF via 65535 steps on an empty board → next step gives gen_count=0x0000, stable=1.

Source files
------------

// File: rtl/life_engine.sv
// life_engine: 16x16 Game of Life board, updated in place one row per cycle.
// Define LIFE_WRAP_EN for a toroidal board; otherwise off-board cells are dead.
module life_engine #(
  parameter int GRID_N = 16,
  parameter int GEN_W = 16,
  localparam int CW = $clog2(GRID_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              toggle,
  input  logic              clear,
  input  logic [CW-1:0]     cur_x,
  input  logic [CW-1:0]     cur_y,
  input  logic [CW-1:0]     rd_row,
  output logic [GRID_N-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              stable,
  output logic [GEN_W-1:0]  gen_count
);
  typedef enum logic {IDLE, COMPUTE} state_t;
  state_t state, state_d;
  logic [GRID_N-1:0][GRID_N-1:0] board;
  logic [GRID_N-1:0] prev_old, up, mid, dn, new_row, top_in, bot_in;
  logic [GRID_N-1:0] ul, ur, ml, mr, dl, dr;
  logic [CW-1:0] r, tog_x, tog_y, ap_x, ap_y;
  logic step_pend, tog_pend, same, go, last, ap_tog;
  logic [3:0] n;
  function automatic logic [GRID_N-1:0] west(input logic [GRID_N-1:0] v);
`ifdef LIFE_WRAP_EN
    return {v[GRID_N-2:0], v[GRID_N-1]};
`else
    return {v[GRID_N-2:0], 1'b0};
`endif
  endfunction
  function automatic logic [GRID_N-1:0] east(input logic [GRID_N-1:0] v);
`ifdef LIFE_WRAP_EN
    return {v[0], v[GRID_N-1:1]};
`else
    return {1'b0, v[GRID_N-1:1]};
`endif
  endfunction
`ifdef LIFE_WRAP_EN
  logic [GRID_N-1:0] row0_old;
  assign top_in = board[GRID_N-1];
  assign bot_in = row0_old;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row0_old <= '0;
    else if (busy && r == '0) row0_old <= mid;
  end
`else
  assign top_in = '0;
  assign bot_in = '0;
`endif
  assign rd_data = board[rd_row];
  assign busy = state == COMPUTE;
  assign go = (step | step_pend) & ~clear & ~toggle;
  assign last = r == CW'(GRID_N - 1);
  assign ap_tog = toggle | tog_pend;
  assign ap_x = toggle ? cur_x : tog_x;
  assign ap_y = toggle ? cur_y : tog_y;
  always_comb begin
    state_d = (state == IDLE) ? (go ? COMPUTE : IDLE) : ((clear | last) ? IDLE : COMPUTE);
  end
  // Row r above comes from prev_old (row r-1 already overwritten), below still old in board.
  always_comb begin
    up = (r == '0) ? top_in : prev_old;
    mid = board[r];
    dn = last ? bot_in : board[r + CW'(1)];
    ul = west(up);
    ur = east(up);
    ml = west(mid);
    mr = east(mid);
    dl = west(dn);
    dr = east(dn);
    n = '0;
    new_row = '0;
    for (int x = 0; x < GRID_N; x++) begin
      n = 4'(ul[x]) + 4'(up[x]) + 4'(ur[x]) + 4'(ml[x]) + 4'(mr[x]) + 4'(dl[x]) + 4'(dn[x]) + 4'(dr[x]);
      new_row[x] = (n == 4'd3) | (mid[x] & (n == 4'd2));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      board <= '0;
      prev_old <= '0;
      r <= '0;
      step_pend <= 1'b0;
      tog_pend <= 1'b0;
      tog_x <= '0;
      tog_y <= '0;
      same <= 1'b0;
      stable <= 1'b0;
      done <= 1'b0;
      gen_count <= '0;
    end else begin
      state <= state_d;
      done <= 1'b0;
      if (state == IDLE) begin
        if (clear) begin
          board <= '0;
          step_pend <= 1'b0;
        end else if (toggle) begin
          board[cur_y][cur_x] <= ~board[cur_y][cur_x];
          step_pend <= step_pend | step;
        end else if (go) begin
          step_pend <= 1'b0;
          r <= '0;
          same <= 1'b1;
        end
      end else if (clear) begin
        board <= '0;
        tog_pend <= 1'b0;
      end else begin
        board[r] <= new_row;
        prev_old <= mid;
        same <= same & (new_row == mid);
        r <= r + CW'(1);
        if (toggle) begin
          tog_pend <= 1'b1;
          tog_x <= cur_x;
          tog_y <= cur_y;
        end
        if (last) begin
          done <= 1'b1;
          gen_count <= gen_count + GEN_W'(1);
          stable <= same & (new_row == mid);
          tog_pend <= 1'b0;
          // The later bit write overrides the row write when the toggle hits row r.
          if (ap_tog) board[ap_y][ap_x] <= ~((ap_y == r) ? new_row[ap_x] : board[ap_y][ap_x]);
        end
      end
    end
  end
endmodule
